// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle between the RV32I core's fetch/LSU requesters, the memory
// arbiter and the memory model. The arbiter uses the slave modport; the
// core/memory side (or a bench standing in for both) uses master.
interface rv32_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    // Fetch requester
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_err;

    // Load/store requester
    logic                  ls_req;
    logic                  ls_we;
    logic [BE_W-1:0]       ls_be;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_WIDTH-1:0] ls_rdata;
    logic                  ls_err;

    // Memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [BE_W-1:0]       mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction outstanding: IDLE -> BUSY -> RESP -> IDLE.
// Build option: ARB_ROUND_ROBIN_EN selects alternating tie-break; when it is
// undefined LS always wins a tie and no last-owner register exists.
module rv32_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                cpurst,
    rv32_mem_arbiter_if.slave   bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  first_q, first_d;
    logic                  we_q, we_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ls_win;
    logic                  timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic                  last_q, last_d;

    // On a tie the side that was not granted last wins
    assign ls_win = bus.ls_req && (!bus.if_req || (last_q == OWN_IF));
`else
    // Fixed priority: LS wins every tie
    assign ls_win = bus.ls_req;
`endif

    // Expiry on the BUSY cycle that would make the wait TIMEOUT_CYCLES long
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // State and command/response registers
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            first_q <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= OWN_IF;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            first_q <= first_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next state: arbitrate and latch in IDLE, wait for ack/timeout in BUSY
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        first_d = 1'b0;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    state_d = BUSY;
                    first_d = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    if (ls_win) begin
                        owner_d = OWN_LS;
                        we_d    = bus.ls_we;
                        be_d    = bus.ls_be;
                        addr_d  = bus.ls_addr;
                        wdata_d = bus.ls_wdata;
                    end else begin
                        owner_d = OWN_IF;
                        we_d    = 1'b0;
                        be_d    = '1;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = ls_win ? OWN_LS : OWN_IF;
`endif
                end
            end
            BUSY: begin
                // An ack on the expiry cycle still counts as a normal completion
                if (bus.mem_ack) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory side: request only while BUSY, fields straight from the latch
    assign bus.mem_req   = (state_q == BUSY);
    assign bus.mem_we    = we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Requester side: only the owner's outputs ever leave zero
    assign bus.if_gnt    = first_q && (owner_q == OWN_IF);
    assign bus.ls_gnt    = first_q && (owner_q == OWN_LS);
    assign bus.if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    assign bus.ls_rvalid = (state_q == RESP) && (owner_q == OWN_LS);
    assign bus.if_rdata  = bus.if_rvalid ? rdata_q : '0;
    assign bus.ls_rdata  = bus.ls_rvalid ? rdata_q : '0;
    assign bus.if_err    = bus.if_rvalid && err_q;
    assign bus.ls_err    = bus.ls_rvalid && err_q;
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: requester and memory models run inside
// a per-cycle tick task; expected responses are queued at stimulus time.
`timescale 1ns/1ps
module tb_rv32_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        logic        side;   // 0 = IF, 1 = LS
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic cpurst;
    always #5 clk = ~clk;

    rv32_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rv32_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .cpurst (cpurst),
        .bus    (bus)
    );

    resp_t       exp_q[$];
    int          if_gnt_cycs[$];
    int          ls_gnt_cycs[$];
    int          rv_cycs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          if_left = 0;
    int          ls_left = 0;
    int          ack_delay = 0;
    int          mem_cnt = 0;
    int          last_run = 0;
    logic        ack_never = 1'b0;
    logic        stray = 1'b0;
    logic [31:0] rd_val = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {bus.if_gnt, bus.if_rvalid, bus.if_err, bus.ls_gnt, bus.ls_rvalid,
                              bus.ls_err, bus.mem_req, bus.mem_we, bus.mem_be}, 64'h0);
        chk({tag, "_rdata"}, {bus.if_rdata, bus.ls_rdata}, 64'h0);
        chk({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, 64'h0);
    endtask

    // One cycle: observe at the falling edge, then drive the next inputs
    task automatic tick();
        resp_t e;
        @(negedge clk);
        cyc++;
        if (!cpurst) begin
            if (bus.if_gnt) begin
                chk("if_gnt_cmd", {bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b0, 4'hF, bus.if_addr});
                chk("if_gnt_wdata", bus.mem_wdata, 64'h0);
                if_gnt_cycs.push_back(cyc);
                if_left--;
            end
            if (bus.ls_gnt) begin
                chk("ls_gnt_cmd", {bus.mem_we, bus.mem_be, bus.mem_addr}, {bus.ls_we, bus.ls_be, bus.ls_addr});
                chk("ls_gnt_wdata", bus.mem_wdata, bus.ls_wdata);
                ls_gnt_cycs.push_back(cyc);
                ls_left--;
            end
            if (bus.if_rvalid || bus.ls_rvalid) begin
                rv_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_side", {bus.if_rvalid, bus.ls_rvalid}, e.side ? 2'b01 : 2'b10);
                    chk("rsp_rdata", e.side ? bus.ls_rdata : bus.if_rdata, e.rdata);
                    chk("rsp_err", e.side ? bus.ls_err : bus.if_err, e.err);
                end
            end
            if (!bus.if_rvalid) chk("if_quiet", {bus.if_rdata, bus.if_err}, 64'h0);
            if (!bus.ls_rvalid) chk("ls_quiet", {bus.ls_rdata, bus.ls_err}, 64'h0);
        end
        // Memory model: ack on BUSY cycle ack_delay+1, or never
        if (!cpurst && bus.mem_req) begin
            mem_cnt++;
            bus.mem_ack   = !ack_never && (mem_cnt == ack_delay + 1);
            bus.mem_rdata = bus.mem_ack ? rd_val : 32'hBAD0_BAD0;
        end else begin
            if (mem_cnt != 0) last_run = mem_cnt;
            mem_cnt       = 0;
            bus.mem_ack   = stray;
            bus.mem_rdata = stray ? 32'h5555_AAAA : 32'h0;
        end
        bus.if_req = (if_left > 0);
        bus.ls_req = (ls_left > 0);
    endtask

    task automatic req_if(input logic [31:0] addr, input int n);
        bus.if_addr = addr;
        if_left     = n;
        bus.if_req  = 1'b1;
    endtask

    task automatic req_ls(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input int n);
        bus.ls_we    = we;
        bus.ls_be    = be;
        bus.ls_addr  = addr;
        bus.ls_wdata = wdata;
        ls_left      = n;
        bus.ls_req   = 1'b1;
    endtask

    task automatic push(input logic side, input logic [31:0] rdata, input logic err);
        resp_t e;
        e.side = side; e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic clear_logs();
        if_gnt_cycs.delete();
        ls_gnt_cycs.delete();
        rv_cycs.delete();
        last_run = 0;
    endtask

    // Run until every queued response arrived and requesters are satisfied
    task automatic drain(input string tag, input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || if_left > 0 || ls_left > 0) && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, exp_q.size() + if_left + ls_left, 64'h0);
        tick();
    endtask

    initial begin
        cpurst        = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_be     = '0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        cpurst = 1'b0;
        tick();

        // Fetch with two wait cycles
        clear_logs();
        ack_delay = 2; rd_val = 32'h0000_0013;
        push(1'b0, 32'h0000_0013, 1'b0);
        req_if(32'h100, 1);
        drain("fetch", 20);
        chk("fetch_gnt_count", if_gnt_cycs.size(), 64'd1);
        if (if_gnt_cycs.size() == 1 && rv_cycs.size() == 1)
            chk("fetch_latency", rv_cycs[0] - if_gnt_cycs[0], 64'd3);

        // Tie between IF and LS, zero-wait loads
        clear_logs();
        ack_delay = 0; rd_val = 32'h0BAD_F00D;
        bus.if_addr = 32'h200;
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b1, rd_val, 1'b0); push(1'b0, rd_val, 1'b0);
        push(1'b1, rd_val, 1'b0); push(1'b0, rd_val, 1'b0);
        req_ls(1'b0, 4'hF, 32'h1000, 32'h0, 2);
        req_if(32'h200, 2);
`else
        push(1'b1, rd_val, 1'b0); push(1'b1, rd_val, 1'b0);
        push(1'b1, rd_val, 1'b0); push(1'b1, rd_val, 1'b0);
        push(1'b0, rd_val, 1'b0);
        req_ls(1'b0, 4'hF, 32'h1000, 32'h0, 4);
        req_if(32'h200, 1);
`endif
        drain("tie", 60);

        // Store, immediate ack: memory read data must not leak back
        clear_logs();
        ack_delay = 0; rd_val = 32'hFFFF_FFFF;
        push(1'b1, 32'h0, 1'b0);
        req_ls(1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF, 1);
        drain("store", 20);
        if (ls_gnt_cycs.size() == 1 && rv_cycs.size() == 1)
            chk("store_latency", rv_cycs[0] - ls_gnt_cycs[0], 64'd1);

        // Ack on the same cycle as timeout expiry completes normally
        clear_logs();
        ack_delay = TO - 1; rd_val = 32'h1234_5678;
        push(1'b1, 32'h1234_5678, 1'b0);
        req_ls(1'b0, 4'hF, 32'h2004, 32'h0, 1);
        drain("ack_at_expiry", 20);
        chk("ack_at_expiry_run", last_run, TO);

        // Timeout: no ack ever
        clear_logs();
        ack_never = 1'b1;
        push(1'b1, 32'h0, 1'b1);
        req_ls(1'b0, 4'hF, 32'h3000, 32'h0, 1);
        drain("timeout", 20);
        chk("timeout_run", last_run, TO);
        ack_never = 1'b0;
        stray = 1'b1;
        tick(); tick(); tick();
        chk("stray_ack_mem_req", bus.mem_req, 64'h0);
        stray = 1'b0;
        tick();

        // Reset while BUSY abandons the access
        clear_logs();
        ack_never = 1'b1;
        req_if(32'h400, 1);
        tick(); tick();
        chk("midreset_busy", bus.mem_req, 64'h1);
        #2 cpurst = 1'b1;
        #1 chk_all_zero("midreset");
        if_left = 0; ls_left = 0;
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        ack_never = 1'b0;
        tick();
        cpurst = 1'b0;
        tick(); tick(); tick();
        chk("midreset_no_rvalid", rv_cycs.size(), 64'h0);
        ack_delay = 1; rd_val = 32'h0000_0093;
        push(1'b0, 32'h0000_0093, 1'b0);
        req_if(32'h404, 1);
        drain("after_reset", 20);
        if (if_gnt_cycs.size() == 1 && rv_cycs.size() == 1)
            chk("after_reset_latency", rv_cycs[0] - if_gnt_cycs[0], 64'd2);

        // Back-to-back fetches with zero-wait memory
        clear_logs();
        ack_delay = 0; rd_val = 32'h0000_0033;
        push(1'b0, rd_val, 1'b0); push(1'b0, rd_val, 1'b0);
        req_if(32'h500, 2);
        drain("b2b", 30);
        chk("b2b_gnts", if_gnt_cycs.size(), 64'd2);
        if (if_gnt_cycs.size() == 2 && rv_cycs.size() == 2) begin
            chk("b2b_gnt_spacing", if_gnt_cycs[1] - if_gnt_cycs[0], 64'd3);
            chk("b2b_rv_to_gnt", if_gnt_cycs[1] - rv_cycs[0], 64'd2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000ns");
        $fatal(1);
    end
endmodule
